// File: rtl/dsp_accum_pkg.sv
// dsp_accum_pkg: shared state encoding and default sizes for the frame accumulator
package dsp_accum_pkg;
  localparam int DEF_WIDTH = 48;
  localparam int DEF_CNTW = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_e;
endpackage

// File: rtl/dsp_frame_accumulator_if.sv
// dsp_frame_accumulator_if: term stream in, frame result out, with valid/ready on both sides
interface dsp_frame_accumulator_if
  import dsp_accum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW = DEF_CNTW
);
  logic in_valid, in_ready, in_sub, in_cin, in_last;
  logic out_valid, out_ready, carryout, ovf;
  logic [WIDTH-1:0] in_data, p;
  logic [CNTW-1:0] count;
  modport master (
    output in_valid, in_data, in_sub, in_cin, in_last, out_ready,
    input in_ready, out_valid, p, carryout, count, ovf
  );
  modport slave (
    input in_valid, in_data, in_sub, in_cin, in_last, out_ready,
    output in_ready, out_valid, p, carryout, count, ovf
  );
endinterface

// File: rtl/accum_addsub_core.sv
// accum_addsub_core: WIDTH+1-bit add/sub of a and (b + cin), top bit is carry or borrow
module accum_addsub_core #(
  parameter int WIDTH = 48
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] r_o,
  output logic             c_o
);
  logic [WIDTH:0] ext_b;
  assign ext_b = {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
  assign {c_o, r_o} = sub_i ? {1'b0, a_i} - ext_b : {1'b0, a_i} + ext_b;
endmodule

// File: rtl/dsp_frame_accumulator.sv
// dsp_frame_accumulator: accumulates a frame of terms into P and hands the result downstream
module dsp_frame_accumulator
  import dsp_accum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW = DEF_CNTW
) (
  input logic clk_i,
  input logic rst_ni,
  input logic clr_i,
  dsp_frame_accumulator_if.slave bus
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] p_q, r;
  logic [CNTW-1:0] cnt_q;
  logic c_q, c, ovf_q, accept, first;
  assign accept = bus.in_valid && bus.in_ready;
  assign first = state_q == IDLE;
  accum_addsub_core #(.WIDTH(WIDTH)) u_core (
    .a_i  (first ? '0 : p_q),
    .b_i  (bus.in_data),
    .cin_i(bus.in_cin),
    .sub_i(bus.in_sub),
    .r_o  (r),
    .c_o  (c)
  );
  always_ff @(posedge clk_i)
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = clr_i ? IDLE :
              state_q == HOLD ? (bus.out_ready ? IDLE : HOLD) :
              accept ? (bus.in_last ? HOLD : ACCUM) : state_q;
  // IN_READY is gated only by reset/clear and the registered state, never by OUT_READY
  always_comb begin
    bus.in_ready = rst_ni && !clr_i && state_q != HOLD;
    bus.out_valid = state_q == HOLD;
  end
  always_ff @(posedge clk_i)
    if (!rst_ni || clr_i) begin
      p_q <= '0;
      c_q <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      p_q <= r;
      c_q <= c;
      cnt_q <= first ? CNTW'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1);
      ovf_q <= first ? 1'b0 : (ovf_q || &cnt_q);
    end
  assign bus.p = p_q;
  assign bus.carryout = c_q;
  assign bus.count = cnt_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_dsp_frame_accumulator.sv
// tb_dsp_frame_accumulator: directed table, corner sequences and a random run against a frame model
module tb_dsp_frame_accumulator;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic in_valid = 1'b0, in_sub = 1'b0, in_cin = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [47:0] in_data = '0;
  int total = 0, bad = 0;
  dsp_frame_accumulator_if #(.WIDTH(48), .CNTW(8)) ia ();
  dsp_frame_accumulator_if #(.WIDTH(48), .CNTW(2)) ib ();
  dsp_frame_accumulator #(.WIDTH(48), .CNTW(8)) dut_a (.clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .bus(ia));
  dsp_frame_accumulator #(.WIDTH(48), .CNTW(2)) dut_b (.clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .bus(ib));
  assign ia.in_valid = in_valid;
  assign ib.in_valid = in_valid;
  assign ia.in_data = in_data;
  assign ib.in_data = in_data;
  assign ia.in_sub = in_sub;
  assign ib.in_sub = in_sub;
  assign ia.in_cin = in_cin;
  assign ib.in_cin = in_cin;
  assign ia.in_last = in_last;
  assign ib.in_last = in_last;
  assign ia.out_ready = out_ready;
  assign ib.out_ready = out_ready;
  always #5 clk = ~clk;
  typedef struct {
    logic [47:0] d;
    logic sub, cin, last;
    logic [47:0] p;
    logic c;
    int cnt;
    logic ov;
  } vec_t;
  vec_t vt[7];
  logic [47:0] m_p;
  logic m_c, m_open, m_hold;
  int m_n;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [47:0] d, input logic sub, input logic cin, input logic last);
    int n = 0;
    while (!ia.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!ia.in_ready) chk("send_ready_timeout", 0, 1);
    {in_data, in_sub, in_cin, in_last, in_valid} = {d, sub, cin, last, 1'b1};
    tick();
    in_valid = 1'b0;
  endtask
  task automatic model_reset();
    {m_p, m_c, m_open, m_hold} = '0;
    m_n = 0;
  endtask
  task automatic model_accept(input logic [47:0] d, input logic sub, input logic cin, input logic last);
    logic [48:0] base, ext, res;
    base = m_open ? {1'b0, m_p} : 49'd0;
    ext = {1'b0, d} + 49'(cin);
    res = sub ? base - ext : base + ext;
    {m_c, m_p} = res;
    m_n = m_open ? m_n + 1 : 1;
    m_open = !last;
    m_hold = last;
  endtask
  task automatic model_chk();
    chk("rnd_p", ia.p, m_p);
    chk("rnd_c", ia.carryout, m_c);
    chk("rnd_cnt8", ia.count, m_n > 255 ? 255 : m_n);
    chk("rnd_ovf8", ia.ovf, m_n > 255);
    chk("rnd_cnt2", ib.count, m_n > 3 ? 3 : m_n);
    chk("rnd_ovf2", ib.ovf, m_n > 3);
    chk("rnd_ovalid", ia.out_valid, m_hold);
  endtask
  initial begin
    logic [47:0] p_hold;
    logic [63:0] rv;
    vt[0] = '{48'd5, 1'b0, 1'b0, 1'b0, 48'd5, 1'b0, 1, 1'b0};
    vt[1] = '{48'd7, 1'b0, 1'b1, 1'b0, 48'd13, 1'b0, 2, 1'b0};
    vt[2] = '{48'd10, 1'b0, 1'b0, 1'b1, 48'd23, 1'b0, 3, 1'b1};
    vt[3] = '{48'd3, 1'b0, 1'b0, 1'b0, 48'd3, 1'b0, 1, 1'b0};
    vt[4] = '{48'd5, 1'b1, 1'b0, 1'b1, 48'hFFFF_FFFF_FFFE, 1'b1, 2, 1'b1};
    vt[5] = '{48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 48'hFFFF_FFFF_FFFF, 1'b0, 1, 1'b0};
    vt[6] = '{48'd1, 1'b0, 1'b0, 1'b1, 48'd0, 1'b1, 2, 1'b1};
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_p", ia.p, 0);
      chk("rst_c", ia.carryout, 0);
      chk("rst_cnt", ia.count, 0);
      chk("rst_ovf", ia.ovf, 0);
      chk("rst_ovalid", ia.out_valid, 0);
      chk("rst_iready", ia.in_ready, 0);
    end
    rst_n = 1'b1;
    #1;
    chk("post_rst_iready", ia.in_ready, 1);
    send(48'd4, 1'b0, 1'b0, 1'b0);
    send(48'd6, 1'b0, 1'b0, 1'b0);
    chk("pre_clr_p", ia.p, 10);
    clr = 1'b1;
    #1;
    chk("clr_iready", ia.in_ready, 0);
    tick();
    clr = 1'b0;
    chk("clr_p", ia.p, 0);
    chk("clr_cnt", ia.count, 0);
    chk("clr_ovalid", ia.out_valid, 0);
    send(48'd9, 1'b0, 1'b0, 1'b1);
    chk("clr_next_p", ia.p, 9);
    chk("clr_next_ovalid", ia.out_valid, 1);
    for (int i = 0; i < 7; i++) begin
      send(vt[i].d, vt[i].sub, vt[i].cin, vt[i].last);
      chk($sformatf("vec%0d_p", i), ia.p, vt[i].p);
      chk($sformatf("vec%0d_c", i), ia.carryout, vt[i].c);
      chk($sformatf("vec%0d_cnt", i), ia.count, vt[i].cnt);
      chk($sformatf("vec%0d_ovalid", i), ia.out_valid, vt[i].ov);
    end
    tick();
    out_ready = 1'b0;
    send(48'd40, 1'b0, 1'b0, 1'b1);
    p_hold = ia.p;
    chk("bp_p_first", p_hold, 40);
    {in_data, in_valid} = {48'd100, 1'b1};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_ovalid", ia.out_valid, 1);
      chk("bp_iready", ia.in_ready, 0);
      chk("bp_p", ia.p, p_hold);
      chk("bp_cnt", ia.count, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_ovalid", ia.out_valid, 0);
    chk("bp_release_iready", ia.in_ready, 1);
    chk("bp_idle_p_kept", ia.p, 40);
    send(48'd2, 1'b0, 1'b0, 1'b1);
    chk("bp_next_frame_p", ia.p, 2);
    for (int i = 0; i < 5; i++) send(48'd1, 1'b0, 1'b0, i == 4);
    chk("sat_cnt2", ib.count, 3);
    chk("sat_ovf2", ib.ovf, 1);
    chk("sat_p", ib.p, 5);
    chk("sat_cnt8", ia.count, 5);
    chk("sat_ovf8", ia.ovf, 0);
    send(48'd1, 1'b0, 1'b0, 1'b1);
    chk("sat_new_cnt2", ib.count, 1);
    chk("sat_new_ovf2", ib.ovf, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      rv = {$urandom, $urandom};
      case ($urandom_range(3))
        0: in_data = '1;
        1: in_data = 48'($urandom_range(15));
        default: in_data = rv[47:0];
      endcase
      in_valid = $urandom_range(3) != 0;
      in_sub = $urandom_range(1) == 1;
      in_cin = $urandom_range(1) == 1;
      in_last = (i < 200) ? $urandom_range(3) == 0 : $urandom_range(15) == 0;
      out_ready = $urandom_range(1) == 1;
      clr = $urandom_range(40) == 0;
      #1;
      chk("rnd_iready", ia.in_ready, !m_hold && !clr);
      if (clr) model_reset();
      else if (m_hold) m_hold = !out_ready;
      else if (in_valid) model_accept(in_data, in_sub, in_cin, in_last);
      tick();
      model_chk();
    end
    {in_valid, clr} = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
